// File: rtl/key_expand.sv
// AES-128 key schedule broadcaster.
// Loads a cipher key and drives the eleven round keys on the shared rkey/addr
// bus, one per clock, so each round stage can capture its key by address.
module key_expand #(
   parameter logic [3:0] IDLE_ADDR = 4'hF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic [127:0] rkey,
   output logic [3:0]   addr,
   output logic         rkey_valid,
   output logic         busy,
   output logic         done
);

   typedef enum logic {S_IDLE, S_EXPAND} state_t;

   // Forward AES S-box, indexed by input byte.
   localparam logic [7:0] SBOX [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Round constant for the key produced at round index r (1..10).
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t         state, state_nxt;
   logic [3:0]     rnd, rnd_nxt, rnd_inc;
   logic [127:0]   rkey_nxt, step_key;
   logic [3:0]     addr_nxt;
   logic           valid_nxt, busy_nxt, done_nxt;
   logic [31:0]    w0, w1, w2, w3, t, w0n, w1n, w2n, w3n;

   // One full round step from the registered key: S-box then the XOR ripple.
   always_comb begin
      {w0, w1, w2, w3} = rkey;
      rnd_inc  = rnd + 4'd1;
      t        = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd_inc), 24'h0};
      w0n      = w0 ^ t;
      w1n      = w1 ^ w0n;
      w2n      = w2 ^ w1n;
      w3n      = w3 ^ w2n;
      step_key = {w0n, w1n, w2n, w3n};
   end

   // Next-state and next-output decode; outputs default to the idle bus.
   always_comb begin
      state_nxt = state;
      rnd_nxt   = rnd;
      rkey_nxt  = rkey;
      addr_nxt  = IDLE_ADDR;
      valid_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (key_load) begin
               rkey_nxt  = key_in;
               addr_nxt  = 4'd0;
               valid_nxt = 1'b1;
               busy_nxt  = 1'b1;
               rnd_nxt   = 4'd0;
               state_nxt = S_EXPAND;
            end
         end
         S_EXPAND: begin
            if (rnd == 4'd10) begin
               // Round 10 was on the bus last cycle; release the bus.
               rnd_nxt   = 4'd0;
               state_nxt = S_IDLE;
            end else begin
               rkey_nxt  = step_key;
               addr_nxt  = rnd_inc;
               valid_nxt = 1'b1;
               busy_nxt  = 1'b1;
               done_nxt  = (rnd_inc == 4'd10);
               rnd_nxt   = rnd_inc;
            end
         end
         default: begin
            rnd_nxt   = 4'd0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, counter and registered bus outputs; reset abandons any broadcast.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         rnd        <= 4'd0;
         rkey       <= 128'h0;
         addr       <= IDLE_ADDR;
         rkey_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         rnd        <= rnd_nxt;
         rkey       <= rkey_nxt;
         addr       <= addr_nxt;
         rkey_valid <= valid_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand. The reference key schedule is built
// from GF(2^8) arithmetic (S-box from multiplicative inverse plus affine map,
// Rcon by repeated doubling) and the word-wise FIPS-197 expansion loop.
module tb_key_expand;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] key_in;
   logic         key_load;
   logic [127:0] rkey;
   logic [3:0]   addr;
   logic         rkey_valid;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]   sbox_m [0:255];
   logic [7:0]   rc_m   [1:10];
   logic [127:0] exp_rk [0:10];
   logic [127:0] cap_rk [0:10];

   localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A1_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [6:0]   IDLE_CTL = {4'hF, 3'b000};

   key_expand #(.IDLE_ADDR(4'hF)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in),
      .key_load   (key_load),
      .rkey       (rkey),
      .addr       (addr),
      .rkey_valid (rkey_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   task automatic build_tables();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      rc_m[1] = 8'h01;
      for (int j = 2; j <= 10; j++) rc_m[j] = xtime(rc_m[j-1]);
   endtask

   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
            tmp = tmp ^ {rc_m[i/4], 24'h0};
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic start_load(input logic [127:0] k);
      key_in   = k;
      key_load = 1'b1;
      step();
      key_load = 1'b0;
      key_in   = rand_key();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; key_load = 1'b0; key_in = rand_key();
      step(); step();
      n_checks++;
      if ({addr, rkey_valid, busy, done} !== IDLE_CTL) begin
         n_fail++; $display("FAIL reset_ctl got %h exp %h", {addr, rkey_valid, busy, done}, IDLE_CTL);
      end
      n_checks++;
      if (rkey !== 128'h0) begin
         n_fail++; $display("FAIL reset_rkey got %h exp 0", rkey);
      end
      // Load on the same edge as reset must be dropped.
      key_load = 1'b1; key_in = rand_key();
      step();
      rst = 1'b0; key_load = 1'b0;
      n_checks++;
      if ({addr, rkey_valid, busy, done} !== IDLE_CTL) begin
         n_fail++; $display("FAIL rst_and_load got %h exp %h", {addr, rkey_valid, busy, done}, IDLE_CTL);
      end
      step();
      n_checks++;
      if ({addr, rkey_valid, busy, done, rkey} !== {IDLE_CTL, 128'h0}) begin
         n_fail++; $display("FAIL rst_and_load_after addr %h busy %b rkey %h exp idle/0", addr, busy, rkey);
      end
   endtask

   task automatic test_broadcast(input logic [127:0] k, input string nm);
      model_expand(k);
      start_load(k);
      cap_rk[0] = rkey;
      n_checks++;
      if ({addr, rkey_valid, busy, done, rkey} !== {4'd0, 3'b110, k}) begin
         n_fail++; $display("FAIL %s round0 got addr %h v%b b%b d%b rkey %h exp addr 0 rkey %h",
                            nm, addr, rkey_valid, busy, done, rkey, k);
      end
      for (int r = 1; r <= 10; r++) begin
         step();
         cap_rk[r] = rkey;
         n_checks++;
         if ({addr, rkey_valid, busy, done} !== {4'(r), 2'b11, (r == 10)}) begin
            n_fail++; $display("FAIL %s ctl r=%0d got %h exp %h", nm, r,
                               {addr, rkey_valid, busy, done}, {4'(r), 2'b11, (r == 10)});
         end
         n_checks++;
         if (rkey !== exp_rk[r]) begin
            n_fail++; $display("FAIL %s rkey r=%0d got %h exp %h", nm, r, rkey, exp_rk[r]);
         end
      end
      step();
      n_checks++;
      if ({addr, rkey_valid, busy, done, rkey} !== {IDLE_CTL, exp_rk[10]}) begin
         n_fail++; $display("FAIL %s end got addr %h v%b b%b d%b rkey %h exp idle rkey %h",
                            nm, addr, rkey_valid, busy, done, rkey, exp_rk[10]);
      end
   endtask

   task automatic test_fips();
      test_broadcast(KEY_A1, "a1");
      n_checks++;
      if ({cap_rk[1], cap_rk[2], cap_rk[10]} !== {A1_R1, A1_R2, A1_R10}) begin
         n_fail++; $display("FAIL a1_vectors got %h %h %h exp %h %h %h",
                            cap_rk[1], cap_rk[2], cap_rk[10], A1_R1, A1_R2, A1_R10);
      end
   endtask

   task automatic test_zero_key();
      test_broadcast(128'h0, "zero");
      n_checks++;
      if ({cap_rk[1], cap_rk[10]} !== {Z_R1, Z_R10}) begin
         n_fail++; $display("FAIL zero_vectors got %h %h exp %h %h", cap_rk[1], cap_rk[10], Z_R1, Z_R10);
      end
   endtask

   task automatic test_random_keys();
      for (int i = 0; i < 6; i++) test_broadcast(rand_key(), "rand");
   endtask

   task automatic test_load_while_busy();
      logic [127:0] k = rand_key();
      model_expand(k);
      start_load(k);
      for (int r = 1; r <= 10; r++) begin
         if (r == 5) begin
            key_load = 1'b1;
            key_in   = ~k;
         end
         step();
         key_load = 1'b0;
         n_checks++;
         if ({addr, busy, done, rkey} !== {4'(r), 1'b1, (r == 10), exp_rk[r]}) begin
            n_fail++; $display("FAIL busy_load r=%0d got addr %h b%b d%b rkey %h exp rkey %h",
                               r, addr, busy, done, rkey, exp_rk[r]);
         end
      end
      step();
      n_checks++;
      if ({addr, rkey_valid, busy, done} !== IDLE_CTL) begin
         n_fail++; $display("FAIL busy_load_end got %h exp %h", {addr, rkey_valid, busy, done}, IDLE_CTL);
      end
      step();
      n_checks++;
      if ({addr, rkey_valid, busy, done} !== IDLE_CTL) begin
         n_fail++; $display("FAIL busy_load_restart got %h exp %h", {addr, rkey_valid, busy, done}, IDLE_CTL);
      end
   endtask

   task automatic test_reset_mid();
      int done_seen = 0;
      start_load(rand_key());
      for (int r = 1; r <= 6; r++) step();
      n_checks++;
      if (addr !== 4'd6) begin
         n_fail++; $display("FAIL rst_mid_pre addr got %h exp 6", addr);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if ({addr, rkey_valid, busy, done, rkey} !== {IDLE_CTL, 128'h0}) begin
         n_fail++; $display("FAIL rst_mid got addr %h v%b b%b d%b rkey %h exp idle/0",
                            addr, rkey_valid, busy, done, rkey);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         if (done !== 1'b0 || addr !== 4'hF) done_seen++;
      end
      n_checks++;
      if (done_seen != 0) begin
         n_fail++; $display("FAIL rst_mid_quiet got %0d active cycles exp 0", done_seen);
      end
      test_broadcast(rand_key(), "after_rst");
   endtask

   task automatic test_back_to_back();
      model_expand(128'h0);
      start_load(128'h0);
      for (int r = 1; r <= 10; r++) begin
         step();
         n_checks++;
         if ({addr, rkey} !== {4'(r), exp_rk[r]}) begin
            n_fail++; $display("FAIL b2b_first r=%0d got addr %h rkey %h exp %h", r, addr, rkey, exp_rk[r]);
         end
      end
      // Load request during the done cycle is seen while still expanding: ignored.
      key_load = 1'b1;
      key_in   = rand_key();
      step();
      n_checks++;
      if ({addr, rkey_valid, busy, done} !== IDLE_CTL) begin
         n_fail++; $display("FAIL b2b_gap got %h exp %h", {addr, rkey_valid, busy, done}, IDLE_CTL);
      end
      model_expand(KEY_A1);
      key_in = KEY_A1;
      step();
      key_load = 1'b0;
      n_checks++;
      if ({addr, rkey_valid, busy, rkey} !== {4'd0, 2'b11, KEY_A1}) begin
         n_fail++; $display("FAIL b2b_second_start got addr %h rkey %h exp 0 %h", addr, rkey, KEY_A1);
      end
      for (int r = 1; r <= 10; r++) begin
         step();
         n_checks++;
         if ({addr, done, rkey} !== {4'(r), (r == 10), exp_rk[r]}) begin
            n_fail++; $display("FAIL b2b_second r=%0d got addr %h d%b rkey %h exp %h", r, addr, done, rkey, exp_rk[r]);
         end
      end
      step();
   endtask

   task automatic test_idle_bus();
      logic [127:0] held = rkey;
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
         key_in   = rand_key();
         key_load = 1'b0;
         step();
         if ({addr, rkey_valid, busy, done, rkey} !== {IDLE_CTL, held}) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL idle_bus got %0d disturbed cycles exp 0 (last addr %h rkey %h)", bad, addr, rkey);
      end
   endtask

   initial begin
      rst = 1'b1; key_load = 1'b0; key_in = 128'h0;
      build_tables();
      test_reset();
      test_fips();
      test_zero_key();
      test_random_keys();
      test_load_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_idle_bus();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
